// File: rtl/match_run_arbiter.sv
// match_run_arbiter: per-channel w1/w2 match-run detection with round-robin event output.
module match_run_arbiter #(
   parameter int NCH    = 4,
   parameter int CHW    = 2,
   parameter int CW     = 3,
   parameter int THRESH = 4
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           en,
   input  logic [NCH-1:0] w1,
   input  logic [NCH-1:0] w2,
   input  logic           evt_ready,
   input  logic           clr_ovr,
   output logic           evt_valid,
   output logic [CHW-1:0] evt_ch,
   output logic [NCH-1:0] overrun
);
   logic [CW-1:0]  run [NCH];
   logic [NCH-1:0] match, evt, pending, load_oh;
   logic [CHW-1:0] ptr, gnt;
   logic           any, free;

   assign match   = ~(w1 ^ w2);
   assign free    = ~evt_valid | evt_ready;
   assign load_oh = (free & any) ? NCH'(1) << gnt : '0;

   always_comb begin
      evt = '0;
      for (int i = 0; i < NCH; i++)
         evt[i] = en & match[i] & (run[i] == CW'(THRESH - 1));
   end

   // Scan downward so the channel closest to ptr wins.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      for (int k = NCH - 1; k >= 0; k--)
         if (pending[ptr + CHW'(k)]) begin
            gnt = ptr + CHW'(k);
            any = 1'b1;
         end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < NCH; i++) run[i] <= '0;
         pending   <= '0;
         ptr       <= '0;
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         overrun   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++)
            run[i] <= (~en | ~match[i]) ? '0 :
                      (run[i] == CW'(THRESH)) ? run[i] : run[i] + CW'(1);
         // A new event on the channel being loaded re-arms its pending bit.
         pending <= (pending & ~load_oh) | evt;
         overrun <= (clr_ovr ? '0 : overrun) | (evt & pending & ~load_oh);
         if (free) begin
            evt_valid <= any;
            if (any) begin
               evt_ch <= gnt;
               ptr    <= gnt + CHW'(1);
            end
         end
      end
   end
endmodule

// File: doc/match_run_arbiter.md
MATCH_RUN_ARBITER -- requirements
Module: match_run_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of monitored w1/w2 channel pairs (fixed at 4 for this release).
REQ-002 Parameter CHW, default 2, channel index width, equal to log2(NCH).
REQ-003 Parameter CW, default 3, per-channel run counter width.
REQ-004 Parameter THRESH, default 4, consecutive-match count that raises an event; legal range 1..2^CW-1.
REQ-005 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  detection enable; low clears run counters and blocks new events.
REQ-008 w1  input  NCH  channel inputs, bit i belongs to channel i.
REQ-009 w2  input  NCH  channel inputs, bit i belongs to channel i.
REQ-010 evt_ready  input  1  consumer accepts the presented event.
REQ-011 clr_ovr  input  1  clears all overrun flags.
REQ-012 evt_valid  output  1  event present on evt_ch; registered.
REQ-013 evt_ch  output  CHW  index of the channel that reached THRESH; registered.
REQ-014 overrun  output  NCH  sticky per-channel lost-event flags; registered.

Function
REQ-015 Per channel i, define match_i = ~(w1[i] ^ w2[i]), sampled each posedge Clock.
REQ-016 Run counter run_i: en=0 or match_i=0 -> 0; else run_i+1, saturating at THRESH.
REQ-017 Event on channel i at edge t: en=1, match_i=1 and run_i==THRESH-1 before the edge; exactly one event per unbroken run.
REQ-018 Event sets pending_i at the same edge; pending_i is internal state only.
REQ-019 Output stage is free when evt_valid=0, or evt_valid=1 and evt_ready=1.
REQ-020 If the output stage is free and any pending bit is set, the load proceeds at that edge:
- Round-robin grant: first set pending_j scanning ptr, ptr+1, ... modulo NCH.
- evt_valid <= 1, evt_ch <= j; pending_j cleared.
- ptr <= (j+1) mod NCH.
REQ-021 If the output stage is free and no pending bit is set: evt_valid <= 0, and evt_ch holds its value.
REQ-022 While evt_valid=1 and evt_ready=0, evt_valid and evt_ch hold stable; no load occurs.
REQ-023 Back-to-back handshakes carry no bubble: with pending work, a handshake at edge t presents the next event from edge t.
REQ-024 Latency: an event at edge t with the output stage free at edge t+1 gives evt_valid=1 after edge t+1.
REQ-025 Simultaneous event and load on the same channel: pending_i stays set (new event kept), and overrun_i is not set.
REQ-026 Event on channel i while pending_i=1 and channel i is not loaded that edge: overrun_i <= 1, and pending_i stays 1 (events merge).
REQ-027 clr_ovr=1 clears all overrun bits; an overrun set at the same edge takes priority over the clear.
REQ-028 en=0 does not clear pending bits or the output stage; already-pending events still drain.
REQ-029 Run counters of different channels are independent; any number of channels may raise events in one cycle.

Reset
REQ-030 Reset=1 at a posedge forces:
- all run_i=0 and all pending_i=0;
- ptr=0;
- evt_valid=0, evt_ch=0;
- overrun=0.
REQ-031 Reset overrides all other inputs, including mid-handshake; a presented event is discarded without acceptance.
REQ-032 After Reset is released, the first event requires THRESH new matching samples.

Verification
REQ-033 Channel 0, w1=w2=1, en=1, evt_ready=1, 4 cycles -> evt_valid=1, evt_ch=0 one edge after the 4th sample, then 0.
REQ-034 Channel 2 matches 3 cycles, mismatches 1 cycle, then matches 4 cycles -> exactly one event (ch 2) after the 8th sample.
REQ-035 Channels 0,1,3 reach THRESH on the same edge with evt_ready=1 -> evt_ch = 0,1,3 on consecutive cycles; next simultaneous burst starts at ch 0 (ptr=0 after wrap from 3).
REQ-036 evt_ready=0 for 10 cycles with ch 1 valid -> evt_ch=1 held stable; then evt_ready=1 -> accepted and evt_valid drops.
REQ-037 Channel 1 pending (not yet loaded) and a second run of 4 matches completes -> overrun=4'b0010; clr_ovr=1 -> overrun=0.
REQ-038 Reset=1 asserted while evt_valid=1 and run_0=3 -> evt_valid=0 next edge, and ch 0 needs 4 new matches to produce an event.
